// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshake on both
// sides, reduction flags on the result and a saturating delivered-result count.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ones,
  output logic             parity,
  output logic [CNT_W-1:0] op_count
);

  logic             s1_v;
  logic             s2_v;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] result;
  logic             adv1;
  logic             adv2;

  // Combinational ready chain: a stage may advance when the one after it
  // is empty or emptying this same cycle, so no bubble is inserted.
  assign adv2      = !s2_v || out_ready;
  assign adv1      = !s1_v || adv2;
  assign in_ready  = adv1 && !rst;
  assign out_valid = s2_v;

  always_comb begin
    result = '0;
    case (s1_op)
      3'd0: result = s1_a & s1_b;
      3'd1: result = s1_a | s1_b;
      3'd2: result = ~(s1_a & s1_b);
      3'd3: result = ~(s1_a | s1_b);
      3'd4: result = ~s1_a;
      3'd5: result = s1_a ^ s1_b;
      3'd6: result = ~(s1_a ^ s1_b);
      3'd7: result = s1_a;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v  <= 1'b0;
      s1_op <= '0;
      s1_a  <= '0;
      s1_b  <= '0;
    end else if (in_valid && in_ready) begin
      s1_v  <= 1'b1;
      s1_op <= op;
      s1_a  <= a;
      s1_b  <= b;
    end else if (adv2) begin
      s1_v  <= 1'b0;
    end
  end

  // Flags are registered alongside y so they always describe the held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v   <= 1'b0;
      y      <= '0;
      zero   <= 1'b0;
      ones   <= 1'b0;
      parity <= 1'b0;
    end else if (adv2 && s1_v) begin
      s2_v   <= 1'b1;
      y      <= result;
      zero   <= (result == '0);
      ones   <= &result;
      parity <= ^result;
    end else if (out_ready) begin
      s2_v   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (s2_v && out_ready && (op_count != {CNT_W{1'b1}})) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: opcode sweep, flags, streaming,
// backpressure, counter saturation (second narrow-counter instance) and reset.
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;

  logic        in_ready, out_valid, zero, ones, parity;
  logic [7:0]  y;
  logic [15:0] op_count;

  logic        in_ready2, out_valid2, zero2, ones2, parity2;
  logic [7:0]  y2;
  logic [1:0]  op_count2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .ones(ones), .parity(parity), .op_count(op_count)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .op(op), .a(a), .b(b), .out_valid(out_valid2), .out_ready(out_ready),
    .y(y2), .zero(zero2), .ones(ones2), .parity(parity2), .op_count(op_count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    case (o)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return ~(x & z);
      3'd3: return ~(x | z);
      3'd4: return ~x;
      3'd5: return x ^ z;
      3'd6: return ~(x ^ z);
      default: return x;
    endcase
  endfunction

  logic [7:0] sweep_y [8];
  logic [1:0] sat_exp [9];
  logic [7:0] flag_a  [3];
  logic       flag_z  [3];
  logic       flag_o  [3];
  logic       flag_p  [3];
  logic [7:0] stream_y [100];

  initial begin
    sweep_y = '{8'h05, 8'hAF, 8'hFA, 8'h50, 8'h5A, 8'hAA, 8'h55, 8'hA5};
    sat_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    flag_a  = '{8'hFF, 8'h00, 8'h01};
    flag_z  = '{1'b0, 1'b1, 1'b0};
    flag_o  = '{1'b1, 1'b0, 1'b0};
    flag_p  = '{1'b0, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00;
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_flags", {29'd0, zero, ones, parity}, 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Opcode sweep, one beat per cycle, with saturation checked on dut_sat.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        in_valid = 1'b1; op = 3'(i); a = 8'hA5; b = 8'h0F;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i < 8) check("sweep_in_ready", 32'(in_ready), 32'd1);
      if (i < 2) begin
        check("sweep_latency_valid", 32'(out_valid), 32'd0);
      end else begin
        check("sweep_valid", 32'(out_valid), 32'd1);
        check("sweep_y", 32'(y), 32'(sweep_y[i-2]));
        check("sweep_parity", 32'(parity), 32'd0);
        check("sweep_op_count", 32'(op_count), 32'(i-2));
        check("sat_op_count", 32'(op_count2), 32'(sat_exp[i-2]));
      end
      cyc();
    end
    check("sweep_final_count", 32'(op_count), 32'd8);
    check("sat_final_count", 32'(op_count2), 32'd3);
    check("sweep_drained", 32'(out_valid), 32'd0);

    // Flags via PASS.
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        in_valid = 1'b1; op = 3'd7; a = flag_a[i]; b = 8'h5C;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i >= 2) begin
        check("flag_y", 32'(y), 32'(flag_a[i-2]));
        check("flag_zero", 32'(zero), 32'(flag_z[i-2]));
        check("flag_ones", 32'(ones), 32'(flag_o[i-2]));
        check("flag_parity", 32'(parity), 32'(flag_p[i-2]));
      end
      cyc();
    end

    // Full-rate streaming after a clean reset so the count starts from zero.
    rst = 1'b1; #1; rst = 1'b0; #1;
    for (int i = 0; i < 102; i++) begin
      if (i < 100) begin
        in_valid = 1'b1;
        op = 3'($urandom_range(0, 7));
        a = 8'($urandom);
        b = 8'($urandom);
        stream_y[i] = model(op, a, b);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i < 100) check("stream_in_ready", 32'(in_ready), 32'd1);
      if (i >= 2) begin
        check("stream_valid", 32'(out_valid), 32'd1);
        check("stream_y", 32'(y), 32'(stream_y[i-2]));
      end
      cyc();
    end
    check("stream_op_count", 32'(op_count), 32'd100);

    // Backpressure: capacity two, y held, order preserved.
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'd5; a = 8'h01; b = 8'h00;
    #1; check("bp_accept1", 32'(in_ready), 32'd1);
    cyc();
    a = 8'h02;
    #1; check("bp_accept2", 32'(in_ready), 32'd1);
    cyc();
    a = 8'h04;
    #1;
    check("bp_full_ready", 32'(in_ready), 32'd0);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_y_first", 32'(y), 32'h01);
    cyc();
    #1;
    check("bp_still_full", 32'(in_ready), 32'd0);
    check("bp_y_held", 32'(y), 32'h01);
    out_ready = 1'b1;
    #1; check("bp_release_ready", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    #1; check("bp_y_second", 32'(y), 32'h02);
    cyc();
    #1;
    check("bp_y_third", 32'(y), 32'h04);
    check("bp_valid_third", 32'(out_valid), 32'd1);
    cyc();
    #1;
    check("bp_drained", 32'(out_valid), 32'd0);
    check("bp_op_count", 32'(op_count), 32'd103);

    // Reset with both stages full and the sink stalled.
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'd0; a = 8'hFF; b = 8'h3C;
    cyc();
    op = 3'd1; a = 8'h0F; b = 8'hF0;
    cyc();
    in_valid = 1'b0;
    #1;
    check("mid_full_valid", 32'(out_valid), 32'd1);
    check("mid_full_y", 32'(y), 32'h3C);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_y", 32'(y), 32'd0);
    check("mid_rst_flags", {29'd0, zero, ones, parity}, 32'd0);
    check("mid_rst_count", 32'(op_count), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    cyc();
    rst = 1'b0;
    #1;
    check("mid_post_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = 3'd1; a = 8'h30; b = 8'h03; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    #1; check("mid_lat_valid", 32'(out_valid), 32'd0);
    cyc();
    #1;
    check("mid_next_valid", 32'(out_valid), 32'd1);
    check("mid_next_y", 32'(y), 32'h33);
    cyc();
    #1;
    check("mid_next_count", 32'(op_count), 32'd1);
    check("mid_next_drained", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
